// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer for a 5-stage RV64 pipeline, with a
//            memory-timeout watchdog and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_z_flag,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_write_en,
    output logic             ex_mem_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             pc_src,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [0:0]        c_ST_RUN    = 1'b0;
    localparam logic [0:0]        c_ST_ERR    = 1'b1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic w_run;
    logic w_mem_stall;
    logic w_branch_taken;
    logic w_load_use_raw;
    logic w_load_use;

    assign w_run          = reset & (state_q == c_ST_RUN);
    assign w_mem_stall    = dmem_req & ~dmem_ready;
    assign w_branch_taken = mem_branch & mem_z_flag & ~w_mem_stall;
    assign w_load_use_raw = ex_mem_read & (ex_rd != 5'd0) &
                            ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                             (id_uses_rs2 & (id_rs2 == ex_rd)));
    // A squashed or frozen ID instruction must not also cost a load-use bubble.
    assign w_load_use     = w_load_use_raw & ~w_mem_stall & ~w_branch_taken;

    always_comb begin
        pc_write_en     = 1'b0;
        if_id_write_en  = 1'b0;
        id_ex_write_en  = 1'b0;
        ex_mem_write_en = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        mem_wb_flush    = 1'b0;
        pc_src          = 1'b0;
        halted          = reset & (state_q == c_ST_ERR);
        if (w_run) begin
            pc_write_en     = 1'b1;
            if_id_write_en  = 1'b1;
            id_ex_write_en  = 1'b1;
            ex_mem_write_en = 1'b1;
            if (w_mem_stall) begin
                pc_write_en     = 1'b0;
                if_id_write_en  = 1'b0;
                id_ex_write_en  = 1'b0;
                ex_mem_write_en = 1'b0;
                mem_wb_flush    = 1'b1;
            end else if (w_branch_taken) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (w_load_use) begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_flush    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == c_ST_RUN) begin
            if (w_mem_stall) begin
                if (wait_cnt_q == c_WAIT_LAST) begin
                    state_d = c_ST_ERR;
                end
                wait_cnt_d = wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_d = '0;
            end
            if ((w_mem_stall || w_load_use) && (stall_cnt_q != c_CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (w_branch_taken && (flush_cnt_q != c_CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= c_ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counters read zero while reset is held, even before the first edge.
    assign stall_count = reset ? stall_cnt_q : '0;
    assign flush_count = reset ? flush_cnt_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    // Output vector order: pc_we, if_id_we, id_ex_we, ex_mem_we,
    // if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, pc_src, halted
    localparam logic [9:0] c_OFF    = 10'b0000000000;
    localparam logic [9:0] c_IDLE   = 10'b1111000000;
    localparam logic [9:0] c_LU     = 10'b0011010000;
    localparam logic [9:0] c_BRANCH = 10'b1111111010;
    localparam logic [9:0] c_MSTALL = 10'b0000000100;
    localparam logic [9:0] c_ERR    = 10'b0000000001;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic             mem_branch, mem_z_flag, dmem_req, dmem_ready;
    logic             pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic             pc_src, halted;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [9:0]       outs;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_z_flag(mem_z_flag),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .pc_src(pc_src), .halted(halted),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign outs = {pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                   pc_src, halted};

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        mem_branch = 1'b0; mem_z_flag = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    // Leaves the bench at a falling edge with reset released and idle inputs.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_load_use();
        dmem_req = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_OFF) begin
            tests_failed++;
            $display("FAIL rst_outs_pre_edge: got %b want %b", outs, c_OFF);
        end
        @(negedge clk);
        tests_run++;
        if (outs !== c_OFF || stall_count !== 3'd0 || flush_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_held: outs %b st %0d fl %0d want %b 0 0",
                     outs, stall_count, flush_count, c_OFF);
        end
        reset = 1'b1;
        set_idle();
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd0 || flush_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_release: outs %b st %0d fl %0d want %b 0 0",
                     outs, stall_count, flush_count, c_IDLE);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use();
        #2;
        tests_run++;
        if (outs !== c_LU) begin
            tests_failed++;
            $display("FAIL lu_stall: got %b want %b", outs, c_LU);
        end
        @(negedge clk);
        tests_run++;
        if (stall_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL lu_count: got %0d want 1", stall_count);
        end
        ex_mem_read = 1'b0;
        #2;
        tests_run++;
        if (outs !== c_IDLE) begin
            tests_failed++;
            $display("FAIL lu_release: got %b want %b", outs, c_IDLE);
        end
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #2;
        tests_run++;
        if (outs !== c_IDLE) begin
            tests_failed++;
            $display("FAIL lu_x0: got %b want %b", outs, c_IDLE);
        end
        @(negedge clk);
        tests_run++;
        if (stall_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL lu_x0_count: got %0d want 1", stall_count);
        end
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_LU) begin
            tests_failed++;
            $display("FAIL lu_rs2: got %b want %b", outs, c_LU);
        end
        @(negedge clk);
        id_uses_rs2 = 1'b0;
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd2) begin
            tests_failed++;
            $display("FAIL lu_rs2_unused: outs %b st %0d want %b 2",
                     outs, stall_count, c_IDLE);
        end
        set_idle();
    endtask

    task automatic test_branch();
        apply_reset();
        set_load_use();
        mem_branch = 1'b1; mem_z_flag = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_BRANCH) begin
            tests_failed++;
            $display("FAIL br_taken: got %b want %b", outs, c_BRANCH);
        end
        @(negedge clk);
        tests_run++;
        if (flush_count !== 3'd1 || stall_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL br_counts: fl %0d st %0d want 1 0", flush_count, stall_count);
        end
        set_idle();
        mem_branch = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_IDLE) begin
            tests_failed++;
            $display("FAIL br_not_taken: got %b want %b", outs, c_IDLE);
        end
        @(negedge clk);
        tests_run++;
        if (flush_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL br_nt_count: got %0d want 1", flush_count);
        end
        set_idle();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                set_load_use();
                mem_branch = 1'b1; mem_z_flag = 1'b1;
            end
            #2;
            tests_run++;
            if (outs !== c_MSTALL) begin
                tests_failed++;
                $display("FAIL mw_stall[%0d]: got %b want %b", i, outs, c_MSTALL);
            end
            @(negedge clk);
        end
        set_idle();
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd3 || flush_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL mw_done: outs %b st %0d fl %0d want %b 3 0",
                     outs, stall_count, flush_count, c_IDLE);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_timeout();
        apply_reset();
        dmem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #2;
            tests_run++;
            if (outs !== c_MSTALL) begin
                tests_failed++;
                $display("FAIL to_stall[%0d]: got %b want %b", i, outs, c_MSTALL);
            end
            @(negedge clk);
        end
        dmem_ready = 1'b1; mem_branch = 1'b1; mem_z_flag = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_ERR) begin
            tests_failed++;
            $display("FAIL to_halt: got %b want %b", outs, c_ERR);
        end
        @(negedge clk);
        set_idle();
        set_load_use();
        #2;
        tests_run++;
        if (outs !== c_ERR || stall_count !== 3'd4 || flush_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL to_frozen: outs %b st %0d fl %0d want %b 4 0",
                     outs, stall_count, flush_count, c_ERR);
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        tests_run++;
        if (outs !== c_OFF) begin
            tests_failed++;
            $display("FAIL to_rst_low: got %b want %b", outs, c_OFF);
        end
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL to_rst_exit: outs %b st %0d want %b 0", outs, stall_count, c_IDLE);
        end
        @(negedge clk);
        // Ready on the final permitted cycle must not trip the watchdog.
        dmem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) @(negedge clk);
        dmem_ready = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_IDLE) begin
            tests_failed++;
            $display("FAIL to_last_ready: got %b want %b", outs, c_IDLE);
        end
        @(negedge clk);
        set_idle();
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL to_no_halt: outs %b st %0d want %b 3", outs, stall_count, c_IDLE);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        dmem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        tests_run++;
        if (outs !== c_OFF) begin
            tests_failed++;
            $display("FAIL rmw_low: got %b want %b", outs, c_OFF);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            #2;
            tests_run++;
            if (outs !== c_MSTALL) begin
                tests_failed++;
                $display("FAIL rmw_stall[%0d]: got %b want %b", i, outs, c_MSTALL);
            end
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #2;
        tests_run++;
        if (outs !== c_IDLE || stall_count !== 3'd3) begin
            tests_failed++;
            $display("FAIL rmw_resume: outs %b st %0d want %b 3", outs, stall_count, c_IDLE);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_saturation();
        int exp;
        apply_reset();
        set_load_use();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp = (i > 7) ? 7 : i;
            tests_run++;
            if (stall_count !== exp[CNT_W-1:0]) begin
                tests_failed++;
                $display("FAIL sat[%0d]: got %0d want %0d", i, stall_count, exp);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline.
- Drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branches resolved in MEM (branch & z_flag from EX/MEM), and multi-cycle data-memory waits.
- Includes a memory-timeout watchdog and saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive cycles dmem_ready may stay low under an active request before the error halt; legal range >= 2.
CNT_W, 32, width of the stall and flush performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  ID/EX mem_read (instruction in EX is a load)
ex_rd  in  5  ID/EX destination register
mem_branch  in  1  EX/MEM branch_out
mem_z_flag  in  1  EX/MEM z_flag_out
dmem_req  in  1  EX/MEM mem_read_out OR mem_write_out
dmem_ready  in  1  data memory completes access this cycle
pc_write_en  out  1  PC update enable
if_id_write_en  out  1  IF/ID load enable
id_ex_write_en  out  1  ID/EX load enable
ex_mem_write_en  out  1  EX/MEM load enable
if_id_flush  out  1  IF/ID loads bubble at next edge
id_ex_flush  out  1  ID/EX loads bubble at next edge
ex_mem_flush  out  1  EX/MEM loads bubble at next edge
mem_wb_flush  out  1  MEM/WB loads bubble at next edge
pc_src  out  1  1 = PC takes branch target from EX/MEM pc_next
halted  out  1  memory timeout error; pipeline frozen
stall_count  out  CNT_W  cycles stalled (load-use or memory)
flush_count  out  CNT_W  taken branches

Behaviour:
- States: RUN, ERR. A wait counter wait_cnt (clog2(MEM_TIMEOUT) bits) runs in RUN.
- Reset (reset==0 at an edge): state=RUN, wait_cnt=0, both counters=0. While reset is low, every output is held inactive: all write_en=0, all flush=0, pc_src=0, halted=0, counters read 0.
- Outputs are combinational from state plus inputs. Defaults in RUN: all write_en=1, all flush=0, pc_src=0.
- Priority in RUN is mem_stall > branch_taken > load_use.
- mem_stall = dmem_req & ~dmem_ready.
  - Drives pc/if_id/id_ex/ex_mem write_en=0 and mem_wb_flush=1.
  - No other flush is asserted.
- branch_taken = mem_branch & mem_z_flag & ~mem_stall.
  - Drives pc_src=1 and if_id_flush=id_ex_flush=ex_mem_flush=1.
  - Write enables stay 1; flush dominates the load.
  - Any load_use in the same cycle is ignored (its instruction is squashed).
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)), applied only when there is no mem_stall and no branch_taken.
  - Drives pc_write_en=0, if_id_write_en=0, id_ex_flush=1.
  - Exactly one bubble per hazard; the condition clears naturally once the load advances.
- wait_cnt:
  - Increments each cycle mem_stall=1.
  - Clears to 0 on any cycle with mem_stall=0.
  - If mem_stall=1 and wait_cnt==MEM_TIMEOUT-1, the next state is ERR.
  - So ERR is entered after MEM_TIMEOUT stalled cycles.
  - dmem_ready arriving on the final cycle completes normally with no error.
- ERR is sticky until reset.
  - Outputs: halted=1, all write_en=0, all flush=0, pc_src=0.
  - Inputs are ignored and counters freeze.
- stall_count increments by 1 on each RUN cycle where mem_stall or load_use is the applied action. It saturates at all-ones.
- flush_count increments by 1 on each RUN cycle with branch_taken. It saturates at all-ones.
- Reset asserted mid-wait or in ERR returns to RUN with counters 0 at that edge.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
  - Required: one cycle of pc_write_en=0, if_id_write_en=0, id_ex_flush=1; stall_count 0->1.
  - Repeat with ex_rd=0: no stall.
- Taken branch: mem_branch=1, mem_z_flag=1 with a simultaneous load-use condition present.
  - Required: pc_src=1; if_id/id_ex/ex_mem_flush=1; pc_write_en=1; flush_count=1; stall_count unchanged.
  - With mem_z_flag=0: no action.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1.
  - Required: 3 cycles of all write_en=0 with mem_wb_flush=1, then normal outputs; stall_count=3.
- Timeout (MEM_TIMEOUT=4): dmem_ready=0 held.
  - Required: halted=1 from cycle 5 onward; all enables 0 while inputs toggle.
  - Repeat with ready on the 4th cycle: no halt.
- Reset mid-wait and in ERR: reset=0 for 1 cycle.
  - Required: halted=0, counters 0, state RUN.
  - Outputs inactive while reset is low; the next idle cycle has all write_en=1.
- Saturation (CNT_W=3): 10 load-use stalls.
  - Required: stall_count stops at 7.
